stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl_if.sv | 23 ++
 rtl/stopwatch_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Button, external-counter and display signals of the stopwatch controller.
// The controller uses the slave modport; whatever drives the buttons and counter uses master.
interface stopwatch_ctrl_if;
  logic        btn_start;
  logic        btn_lap;
  logic        btn_clr;
  logic [15:0] cnt_q;
  logic        cnt_en;
  logic        cnt_clrn;
  logic [15:0] disp_val;
  logic [1:0]  state;
  logic        ovf;

  modport master (
    output btn_start, btn_lap, btn_clr, cnt_q,
    input  cnt_en, cnt_clrn, disp_val, state, ovf
  );

  modport slave (
    input  btn_start, btn_lap, btn_clr, cnt_q,
    output cnt_en, cnt_clrn, disp_val, state, ovf
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button FSM, tick prescaler, lap display freeze and overflow flag.
// Optional macro STOPWATCH_CTRL_SATURATE_EN stops the count at FFFF instead of wrapping.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic             clk,
  input  logic             clearn,
  stopwatch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_t          r_state;
  state_t          w_state_nx;
  logic [PW-1:0]   r_presc;
  logic            r_start_d;
  logic            r_lap_d;
  logic            r_clr_d;
  logic            r_clrn;
  logic [15:0]     r_disp;
  logic            r_ovf;

  logic            w_ev_start;
  logic            w_ev_lap;
  logic            w_ev_clr;
  logic            w_counting;
  logic            w_tick;
  logic            w_sat;
  logic            w_cnt_en;
  logic            w_clr_pulse;
  logic            w_ovf_set;
  logic            w_disp_hold;

  assign w_ev_start = bus.btn_start & ~r_start_d;
  assign w_ev_lap   = bus.btn_lap   & ~r_lap_d;
  assign w_ev_clr   = bus.btn_clr   & ~r_clr_d;

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Each state checks only its valid events, highest priority first (clr > start > lap).
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_ev_clr && w_ev_start) w_state_nx = S_RUN;
      end
      S_RUN: begin
        if (w_ev_start)    w_state_nx = S_PAUSE;
        else if (w_ev_lap) w_state_nx = S_LAP;
      end
      S_LAP: begin
        if (w_ev_start)    w_state_nx = S_PAUSE;
        else if (w_ev_lap) w_state_nx = S_RUN;
      end
      S_PAUSE: begin
        if (w_ev_clr)        w_state_nx = S_IDLE;
        else if (w_ev_start) w_state_nx = S_RUN;
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (w_sat) w_state_nx = S_PAUSE;
  end

  always_comb begin
    w_counting  = (r_state == S_RUN) || (r_state == S_LAP);
    w_tick      = w_counting && (r_presc == PRESC_MAX);
    w_sat       = 1'b0;
`ifdef STOPWATCH_CTRL_SATURATE_EN
    w_sat       = w_tick && (bus.cnt_q == 16'hFFFF);
`endif
    w_cnt_en    = w_tick && !w_sat && r_clrn;
    w_clr_pulse = w_ev_clr && ((r_state == S_IDLE) || (r_state == S_PAUSE));
    w_ovf_set   = (w_cnt_en || w_sat) && (bus.cnt_q == 16'hFFFF);
    w_disp_hold = (r_state == S_LAP) && (w_state_nx == S_LAP);
  end

  // Capture on lap entry comes from the RUN cycle; release samples on the exit cycle itself.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      r_start_d <= 1'b0;
      r_lap_d   <= 1'b0;
      r_clr_d   <= 1'b0;
      r_presc   <= '0;
      r_clrn    <= 1'b0;
      r_disp    <= 16'h0000;
      r_ovf     <= 1'b0;
    end else begin
      r_start_d <= bus.btn_start;
      r_lap_d   <= bus.btn_lap;
      r_clr_d   <= bus.btn_clr;
      r_clrn    <= ~w_clr_pulse;

      if (w_state_nx == S_IDLE) begin
        r_presc <= '0;
      end else if (w_counting) begin
        r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + PW'(1);
      end

      if (!w_disp_hold) begin
        r_disp <= bus.cnt_q;
      end

      if (w_clr_pulse) begin
        r_ovf <= 1'b0;
      end else if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.cnt_en   = w_cnt_en;
  assign bus.cnt_clrn = r_clrn;
  assign bus.disp_val = r_disp;
  assign bus.state    = r_state;
  assign bus.ovf      = r_ovf;

endmodule
